// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_pkg
//  Purpose  : Shared definitions for the LED PIO sequencer: register map,
//             CTRL/STATUS bit positions, mode encodings and FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    // Register map of the CPU-facing slave
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PATTERN = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_MODE_LSB   = 1;
    localparam int CTRL_IRQ_EN_BIT = 3;

    // STATUS bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_CUR_LSB  = 4;
    localparam int STATUS_IRQ_BIT  = 8;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_TICK = 2'd2,
        ST_WRITE     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/led_seq_step.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_step
//  Purpose  : Combinational next-pattern generator. Given the mode, the
//             current LED value and the configured pattern, produces the
//             value for the next step and flags a wrap (sequence restart).
//  Revision : 1.0 - initial release
// ============================================================================
module led_seq_step
    import led_seq_pkg::*;
#(
    parameter int LED_W = 4
) (
    input  mode_t            mode,
    input  logic [LED_W-1:0] cur,
    input  logic [LED_W-1:0] pattern,
    output logic [LED_W-1:0] nxt,
    output logic             wrap
);

    // Next value and wrap detection per mode; static mode never steps.
    always_comb begin
        nxt  = cur;
        wrap = 1'b0;
        case (mode)
            MODE_BLINK: begin
                // Alternates PATTERN / 0; the return to PATTERN is the wrap.
                nxt  = (cur == pattern) ? '0 : pattern;
                wrap = (cur != pattern);
            end
            MODE_SHIFT: begin
                nxt  = {cur[LED_W-2:0], cur[LED_W-1]};
                // An all-zero pattern never moves, so it never wraps.
                wrap = (pattern != '0) && ({cur[LED_W-2:0], cur[LED_W-1]} == pattern);
            end
            MODE_COUNT: begin
                nxt  = cur + 1'b1;
                wrap = &cur;
            end
            MODE_STATIC: begin
                nxt  = cur;
                wrap = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/led_pio_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : led_pio_sequencer
//  Purpose  : Autonomous LED pattern sequencer. A CPU programs mode, pattern
//             and step period through a small Avalon-MM slave; the block
//             then writes successive LED values to the PIO s1 port through
//             its Avalon-MM master without CPU involvement.
//  Options  : SEQ_IRQ_EN - adds the irq output, CTRL[3] irq enable and the
//             STATUS[8] wrap flag (write 1 to clear).
//  Revision : 1.0 - initial release
// ============================================================================
module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int                  LED_W      = 4,
    parameter int                  PERIOD_W   = 24,
    parameter logic [PERIOD_W-1:0] PERIOD_RST = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
`ifdef SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic                ctrl_en;
    mode_t               ctrl_mode;
    logic [LED_W-1:0]    pattern_reg;
    logic [PERIOD_W-1:0] period_reg;

    state_t              state;
    logic [LED_W-1:0]    cur;
    logic [PERIOD_W-1:0] tick_cnt;
    logic                cfg_pending;

    logic                reg_wr;
    logic                ctrl_wr;
    logic                enable_next;
    logic                cfg_change;
    logic [PERIOD_W-1:0] period_last;
    logic                tick_done;
    logic [LED_W-1:0]    load_val;
    logic [LED_W-1:0]    step_nxt;
    logic                step_wrap;
    logic                unused_bits;

    assign m_address   = 2'd0;
    assign reg_wr      = s_chipselect && !s_write_n;
    assign ctrl_wr     = reg_wr && (s_address == REG_CTRL);
    // A CTRL write takes effect on the enable in the same cycle it lands.
    assign enable_next = ctrl_wr ? s_writedata[CTRL_EN_BIT] : ctrl_en;
    // Reconfiguration while running restarts the sequence from LOAD.
    assign cfg_change  = ctrl_en && reg_wr &&
                         ((s_address == REG_PATTERN) || (s_address == REG_PERIOD) ||
                          (ctrl_wr && (s_writedata[CTRL_MODE_LSB +: 2] != ctrl_mode)));
    // A programmed period of 0 behaves like 1.
    assign period_last = (period_reg == '0) ? '0 : period_reg - 1'b1;
    assign tick_done   = (tick_cnt == period_last);
    assign load_val    = (ctrl_mode == MODE_COUNT) ? '0 : pattern_reg;
    assign unused_bits = ^{s_writedata[31:PERIOD_W], step_wrap};

    led_seq_step #(
        .LED_W   (LED_W)
    ) u_step (
        .mode    (ctrl_mode),
        .cur     (cur),
        .pattern (pattern_reg),
        .nxt     (step_nxt),
        .wrap    (step_wrap)
    );

`ifdef SEQ_IRQ_EN
    logic irq_en;
    logic irq_flag;
    logic wrap_evt;

    // A wrap counts even when a concurrent CTRL write pre-empts the step.
    assign wrap_evt = (state == ST_WAIT_TICK) && (ctrl_mode != MODE_STATIC) &&
                      tick_done && step_wrap;
    assign irq      = irq_flag & irq_en;

    // Sticky wrap flag: set wins over a write-1-to-clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_flag <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (wrap_evt)
                irq_flag <= 1'b1;
            else if (reg_wr && (s_address == REG_STATUS) && s_writedata[STATUS_IRQ_BIT])
                irq_flag <= 1'b0;
            if (ctrl_wr)
                irq_en <= s_writedata[CTRL_IRQ_EN_BIT];
        end
    end
`endif

    // CPU-visible configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_mode   <= MODE_STATIC;
            pattern_reg <= '0;
            period_reg  <= PERIOD_RST;
        end else if (reg_wr) begin
            case (s_address)
                REG_CTRL: begin
                    ctrl_en   <= s_writedata[CTRL_EN_BIT];
                    ctrl_mode <= mode_t'(s_writedata[CTRL_MODE_LSB +: 2]);
                end
                REG_PATTERN: pattern_reg <= s_writedata[LED_W-1:0];
                REG_PERIOD:  period_reg  <= s_writedata[PERIOD_W-1:0];
                default: ;
            endcase
        end
    end

    // Sequencer FSM with registered Avalon master outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cur          <= '0;
            tick_cnt     <= '0;
            cfg_pending  <= 1'b0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tick_cnt    <= '0;
                    cfg_pending <= 1'b0;
                    if (enable_next)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    tick_cnt    <= '0;
                    cfg_pending <= 1'b0;
                    if (!enable_next) begin
                        state <= ST_IDLE;
                    end else if (!cfg_change) begin
                        // A config write landing now would be missed: stay in LOAD.
                        cur          <= load_val;
                        m_writedata  <= 32'(load_val);
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        state        <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!m_waitrequest) begin
                        m_chipselect <= 1'b0;
                        m_write_n    <= 1'b1;
                        tick_cnt     <= '0;
                        cfg_pending  <= 1'b0;
                        if (!enable_next)
                            state <= ST_IDLE;
                        else if (cfg_pending || cfg_change)
                            state <= ST_LOAD;
                        else
                            state <= ST_WAIT_TICK;
                    end else if (cfg_change) begin
                        cfg_pending <= 1'b1;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!enable_next) begin
                        tick_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (cfg_change) begin
                        tick_cnt <= '0;
                        state    <= ST_LOAD;
                    end else if (ctrl_mode == MODE_STATIC) begin
                        // Static mode holds here with the counter frozen.
                        tick_cnt <= tick_cnt;
                    end else if (tick_done) begin
                        tick_cnt     <= '0;
                        cur          <= step_nxt;
                        m_writedata  <= 32'(step_nxt);
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        state        <= ST_WRITE;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Zero-wait combinational register read mux; undefined bits read 0.
    always_comb begin
        s_readdata = '0;
        case (s_address)
            REG_CTRL: begin
                s_readdata[CTRL_EN_BIT]          = ctrl_en;
                s_readdata[CTRL_MODE_LSB +: 2]   = ctrl_mode;
`ifdef SEQ_IRQ_EN
                s_readdata[CTRL_IRQ_EN_BIT]      = irq_en;
`endif
            end
            REG_PATTERN: s_readdata[LED_W-1:0]    = pattern_reg;
            REG_PERIOD:  s_readdata[PERIOD_W-1:0] = period_reg;
            REG_STATUS: begin
                s_readdata[STATUS_BUSY_BIT]          = (state != ST_IDLE);
                s_readdata[STATUS_CUR_LSB +: LED_W]  = cur;
`ifdef SEQ_IRQ_EN
                s_readdata[STATUS_IRQ_BIT]           = irq_flag;
`endif
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
